// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: register map, bit
// positions and scheduler state encoding.
package uart_pkg;

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;

  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_ACTIVE  = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;

  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_IE = 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } sched_state_t;

  // FIFO occupancy as shown in the 4-bit STATUS count field
  function automatic logic [3:0] sat_count(input logic [4:0] c);
    return (c > 5'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmit path; power-of-two depth with wrap-around
// read/write pointers and an explicit occupancy counter.
module uart_tx_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// APB-programmed UART transmit scheduler: queues bytes and launches them one
// frame at a time. Define UART_TX_IRQ_EN to build the empty/overflow interrupt.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  sched_state_t  state;
  sched_state_t  state_nxt;
  logic          access;
  logic          wr_data;
  logic          wr_status;
  logic          wr_ctrl;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          active;
  logic [CW-1:0] count;
  logic [7:0]    head;
  logic [7:0]    tx_data_q;
  logic [7:0]    status;
  logic [7:0]    ctrl_rd;
  logic          ovf;
  logic          en;
  logic          ie;

  assign access    = PSEL && PENABLE;
  assign PREADY    = access && !PRESET;
  assign wr_data   = access && PWRITE && (PADDR == ADDR_DATA);
  assign wr_status = access && PWRITE && (PADDR == ADDR_STATUS);
  assign wr_ctrl   = access && PWRITE && (PADDR == ADDR_CTRL);
  assign push      = wr_data && !full;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (PCLK),
    .rst   (PRESET),
    .push  (push),
    .pop   (pop),
    .wdata (PWDATA),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Full is sampled before any same-cycle pop, so a write into a full FIFO always drops
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ovf <= 1'b0;
    end else if (wr_data && full) begin
      ovf <= 1'b1;
    end else if (wr_status && PWDATA[ST_OVF]) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      en <= 1'b0;
    end else if (wr_ctrl) begin
      en <= PWDATA[CTRL_EN];
    end
  end

`ifdef UART_TX_IRQ_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ie <= 1'b0;
    end else if (wr_ctrl) begin
      ie <= PWDATA[CTRL_IE];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      irq <= 1'b0;
    end else begin
      irq <= ie && (empty || ovf);
    end
  end
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    pop       = 1'b0;
    active    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && !empty) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        tx_start  = 1'b1;
        pop       = 1'b1;
        active    = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        active = 1'b1;
        if (tx_done) state_nxt = GAP;
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The head is shown directly during LAUNCH and held afterwards until the next launch
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_data_q <= '0;
    end else if (state == LAUNCH) begin
      tx_data_q <= head;
    end
  end

  assign tx_data = (state == LAUNCH) ? head : tx_data_q;

  always_comb begin
    status                      = '0;
    status[ST_EMPTY]            = empty;
    status[ST_FULL]             = full;
    status[ST_ACTIVE]           = active;
    status[ST_OVF]              = ovf;
    status[ST_CNT_LSB +: 4]     = sat_count(5'(count));
    ctrl_rd                     = '0;
    ctrl_rd[CTRL_EN]            = en;
    ctrl_rd[CTRL_IE]            = ie;
  end

  always_comb begin
    PRDATA = '0;
    if (!PRESET && access && !PWRITE) begin
      case (PADDR)
        ADDR_STATUS: PRDATA = status;
        ADDR_CTRL:   PRDATA = ctrl_rd;
        default:     PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler; build with UART_TX_IRQ_EN defined
// to exercise the interrupt build.
module tb_uart_tx_scheduler;

  localparam int DEPTH = 8;
  localparam logic [7:0] A_DATA   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_CTRL   = 8'h08;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       irq;

  uart_tx_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .irq      (irq)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Record every launch observed on the transmitter interface
  logic [7:0] launch_data[$];
  int         launch_cyc[$];
  always @(negedge PCLK) begin
    if (tx_start) begin
      launch_data.push_back(tx_data);
      launch_cyc.push_back(cyc);
    end
  end

  // Reference model: accepted bytes in order, overflow flag, enable, completed frames
  logic [7:0] exp_all[$];
  bit         exp_ovf = 1'b0;
  bit         exp_en  = 1'b0;
  int         lbase   = 0;
  int         ndone   = 0;
  int         dcyc    = 0;
  int         wr_cyc  = 0;
  int         errors  = 0;
  int         checks  = 0;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  function automatic int occupancy();
    return exp_all.size() - (launch_data.size() - lbase);
  endfunction

  function automatic logic [7:0] exp_status(input bit act);
    int occ;
    logic [3:0] c;
    occ = occupancy();
    c = (occ > 15) ? 4'd15 : 4'(occ);
    return {c, exp_ovf, act, (occ == DEPTH), (occ == 0)};
  endfunction

  task automatic apb_write(input logic [7:0] addr, input logic [7:0] data);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    wr_cyc  = cyc;
    // Fullness is judged before any launch popping in this same cycle
    if (addr == A_DATA) begin
      if (occupancy() < DEPTH) exp_all.push_back(data);
      else exp_ovf = 1'b1;
    end else if (addr == A_STATUS) begin
      if (data[3]) exp_ovf = 1'b0;
    end else if (addr == A_CTRL) begin
      exp_en = data[0];
    end
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [7:0] data, output logic rdy);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    #1;
    data = PRDATA;
    rdy  = PREADY;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_launch(input int n, input int budget, output bit ok);
    int k = 0;
    while (launch_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (launch_data.size() >= n);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    dcyc    = cyc;
    ndone++;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic r;
    PRESET = 1'b1; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = A_STATUS;
    PWDATA = '0; tx_done = 1'b0;
    repeat (3) tick();
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b want 0", PREADY); end
    checks++; if (PRDATA !== 8'h00) begin errors++; $display("FAIL reset_prdata: got %h want 00", PRDATA); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
    tick();
    apb_read(A_STATUS, d, r);
    checks++; if (d !== 8'h01 || r !== 1'b1) begin errors++; $display("FAIL reset_status: got %h/%b want 01/1", d, r); end
    apb_write(8'h10, 8'hFF);
    apb_read(8'h0C, d, r);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped_read: got %h want 00", d); end
    apb_write(A_CTRL, 8'hFC);
    apb_read(A_CTRL, d, r);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL ctrl_reserved: got %h want 00", d); end
  endtask

  task automatic test_single();
    logic [7:0] d;
    logic r;
    bit ok;
    int n0;
    int w;
    apb_write(A_CTRL, 8'h01);
    n0 = launch_data.size();
    apb_write(A_DATA, 8'h55);
    w = wr_cyc;
    wait_launch(n0 + 1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_launch: no tx_start within 20 cycles"); end
    if (ok) begin
      checks++; if (launch_data[n0] !== 8'h55) begin errors++; $display("FAIL single_data: got %h want 55", launch_data[n0]); end
      // write cycle, one idle cycle, then the launch cycle
      checks++; if (launch_cyc[n0] != w + 2) begin errors++; $display("FAIL single_latency: got %0d want %0d", launch_cyc[n0] - w, 2); end
    end
    apb_read(A_STATUS, d, r);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL single_active: got %h want 05", d); end
    pulse_done();
    apb_read(A_STATUS, d, r);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL single_after_gap: got %h want 01", d); end
    checks++; if (tx_data !== 8'h55) begin errors++; $display("FAIL single_hold: got %h want 55", tx_data); end
    checks++; if (launch_data.size() != n0 + 1) begin errors++; $display("FAIL single_count: got %0d want %0d", launch_data.size() - n0, 1); end
    // A stray done while idle must not shorten the next frame
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    apb_write(A_DATA, 8'h3C);
    wait_launch(n0 + 2, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stray_launch: no tx_start within 20 cycles"); end
    repeat (4) tick();
    apb_read(A_STATUS, d, r);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL stray_done_ignored: got %h want 05", d); end
    pulse_done();
    repeat (2) tick();
  endtask

  task automatic test_fill_order();
    logic [7:0] d;
    logic r;
    bit ok;
    int n0;
    apb_write(A_CTRL, 8'h00);
    for (int i = 1; i <= 8; i++) apb_write(A_DATA, 8'(i));
    apb_read(A_STATUS, d, r);
    checks++; if (d !== 8'h82) begin errors++; $display("FAIL fill_full: got %h want 82", d); end
    apb_write(A_DATA, 8'hEE);
    apb_read(A_STATUS, d, r);
    checks++; if (d !== 8'h8A) begin errors++; $display("FAIL fill_overflow: got %h want 8a", d); end
    apb_write(A_STATUS, 8'hF7);
    apb_read(A_STATUS, d, r);
    checks++; if (d !== 8'h8A) begin errors++; $display("FAIL ovf_no_clear: got %h want 8a", d); end
    apb_write(A_STATUS, 8'h08);
    apb_read(A_STATUS, d, r);
    checks++; if (d !== 8'h82) begin errors++; $display("FAIL ovf_clear: got %h want 82", d); end
    n0 = launch_data.size();
    apb_write(A_CTRL, 8'h01);
    for (int i = 0; i < 8; i++) begin
      wait_launch(n0 + i + 1, 40, ok);
      checks++; if (!ok) begin errors++; $display("FAIL order_launch%0d: timeout", i); end
      if (!ok) break;
      checks++; if (launch_data[n0 + i] !== 8'(i + 1)) begin errors++; $display("FAIL order_data%0d: got %h want %h", i, launch_data[n0 + i], 8'(i + 1)); end
      if (i > 0) begin
        // done cycle, GAP, IDLE, then LAUNCH
        checks++; if (launch_cyc[n0 + i] != dcyc + 3) begin errors++; $display("FAIL order_spacing%0d: got %0d want 3", i, launch_cyc[n0 + i] - dcyc); end
      end
      repeat ($urandom_range(0, 3)) tick();
      pulse_done();
    end
    repeat (4) tick();
    checks++; if (launch_data.size() != n0 + 8) begin errors++; $display("FAIL order_total: got %0d want 8", launch_data.size() - n0); end
    apb_read(A_STATUS, d, r);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL order_drained: got %h want 01", d); end
  endtask

  task automatic test_push_pop_enable();
    logic [7:0] d;
    logic r;
    bit ok;
    int n0;
    apb_write(A_CTRL, 8'h00);
    apb_write(A_DATA, 8'hA1);
    apb_write(A_DATA, 8'hA2);
    apb_write(A_DATA, 8'hA3);
    n0 = launch_data.size();
    apb_write(A_CTRL, 8'h01);
    apb_write(A_DATA, 8'hA4);
    wait_launch(n0 + 1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pushpop_launch: timeout"); end
    if (ok) begin
      checks++; if (launch_cyc[n0] != wr_cyc) begin errors++; $display("FAIL pushpop_same_cycle: launch %0d write %0d", launch_cyc[n0], wr_cyc); end
      checks++; if (launch_data[n0] !== 8'hA1) begin errors++; $display("FAIL pushpop_data: got %h want a1", launch_data[n0]); end
    end
    apb_read(A_STATUS, d, r);
    checks++; if (d !== 8'h34 || d !== exp_status(1'b1)) begin errors++; $display("FAIL pushpop_count: got %h want 34", d); end
    apb_write(A_CTRL, 8'h00);
    pulse_done();
    repeat (20) tick();
    checks++; if (launch_data.size() != n0 + 1) begin errors++; $display("FAIL disable_no_launch: got %0d want 1", launch_data.size() - n0); end
    apb_read(A_STATUS, d, r);
    checks++; if (d !== 8'h30) begin errors++; $display("FAIL disable_status: got %h want 30", d); end
  endtask

  task automatic test_irq();
    logic [7:0] d;
    logic r;
    bit ok;
    int n0;
    n0 = launch_data.size();
    apb_write(A_CTRL, 8'h03);
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_nonempty: got %b want 0", irq); end
    apb_read(A_CTRL, d, r);
`ifdef UART_TX_IRQ_EN
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL irq_ctrl_rd: got %h want 03", d); end
`else
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL irq_ctrl_rd: got %h want 01", d); end
`endif
    for (int i = 0; i < 3; i++) begin
      wait_launch(n0 + i + 1, 40, ok);
      checks++; if (!ok) begin errors++; $display("FAIL irq_drain%0d: timeout", i); end
      if (!ok) break;
      checks++; if (launch_data[n0 + i] !== exp_all[n0 + i - lbase]) begin errors++; $display("FAIL irq_data%0d: got %h want %h", i, launch_data[n0 + i], exp_all[n0 + i - lbase]); end
      pulse_done();
    end
    repeat (4) tick();
`ifdef UART_TX_IRQ_EN
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_empty: got %b want 1", irq); end
`else
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_empty: got %b want 0", irq); end
`endif
    apb_write(A_CTRL, 8'h01);
    repeat (2) tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b want 0", irq); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    logic r;
    bit ok;
    apb_write(A_CTRL, 8'h00);
    apb_write(A_DATA, 8'h71);
    apb_write(A_DATA, 8'h72);
    apb_write(A_CTRL, 8'h01);
    wait_launch(launch_data.size() + 1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_launch: timeout"); end
    PRESET = 1'b1;
    tick();
    checks++; if (tx_data !== 8'h00 || tx_start !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got %h/%b want 00/0", tx_data, tx_start); end
    tick();
    PRESET = 1'b0;
    exp_all.delete();
    lbase   = launch_data.size();
    ndone   = launch_data.size();
    exp_ovf = 1'b0;
    exp_en  = 1'b0;
    tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    apb_read(A_STATUS, d, r);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL midreset_status: got %h want 01", d); end
    apb_write(A_CTRL, 8'h01);
    repeat (8) tick();
    checks++; if (launch_data.size() != lbase) begin errors++; $display("FAIL midreset_discard: got %0d launches want 0", launch_data.size() - lbase); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic r;
    int  nstart;
    int  e0;
    bit  pdone = 1'b0;
    bit  rto   = 1'b0;
    nstart = launch_data.size();
    e0     = exp_all.size();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 6)) tick();
          apb_write(A_DATA, 8'($urandom));
        end
        pdone = 1'b1;
      end
      begin
        int k = 0;
        while (!(pdone && (launch_data.size() - lbase == exp_all.size()) && (launch_data.size() == ndone)) && k < 4000) begin
          if (launch_data.size() > ndone) begin
            repeat ($urandom_range(0, 8)) tick();
            pulse_done();
          end else begin
            tick();
          end
          k++;
        end
        rto = (k >= 4000);
      end
    join
    checks++; if (rto) begin errors++; $display("FAIL random_timeout: %0d launches of %0d accepted", launch_data.size() - nstart, exp_all.size() - e0); end
    for (int j = 0; j < exp_all.size() - e0 && nstart + j < launch_data.size(); j++) begin
      checks++;
      if (launch_data[nstart + j] !== exp_all[e0 + j]) begin
        errors++;
        $display("FAIL random_data%0d: got %h want %h", j, launch_data[nstart + j], exp_all[e0 + j]);
      end
    end
    repeat (3) tick();
    apb_read(A_STATUS, d, r);
    checks++; if (d !== exp_status(1'b0)) begin errors++; $display("FAIL random_status: got %h want %h", d, exp_status(1'b0)); end
    apb_write(A_STATUS, 8'h08);
    apb_read(A_STATUS, d, r);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL random_final: got %h want 01", d); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_order();
    test_push_pop_enable();
    test_irq();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
